// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Step counter must hold values 0..WIDTH-1 with headroom.
  function automatic int step_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring shift-subtract step; reused every RUN cycle.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  // Shifted remainder needs WIDTH+1 bits; after the step it fits in WIDTH again.
  always_comb begin
    r_sh  = {rem_i, bit_i};
    diff  = r_sh - {1'b0, div_i};
    q_o   = (r_sh >= {1'b0, div_i});
    rem_o = q_o ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional two's-complement mode under `SIGNED_DIV_EN.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = step_cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fin_quo, fin_rem;
  logic             last;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (r_q),
    .bit_i (wq_q[WIDTH-1]),
    .div_i (dv_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand magnitudes at accept and sign fix-up at the final step.
  always_comb begin
    fin_quo = {wq_q[WIDTH-2:0], step_q};
    fin_rem = step_rem;
`ifdef SIGNED_DIV_EN
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    if (qneg_q) fin_quo = ~fin_quo + 1'b1;
    if (rneg_q) fin_rem = ~fin_rem + 1'b1;
`else
    mag_a = a;
    mag_b = b;
`endif
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    wq_d    = wq_q;
    dv_d    = dv_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quo_d  = '1;
            rem_d  = a;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            r_d     = '0;
            wq_d    = mag_a;
            dv_d    = mag_b;
            dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d  = a[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        r_d   = step_rem;
        wq_d  = {wq_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          quo_d   = fin_quo;
          rem_d   = fin_rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      wq_q    <= '0;
      dv_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      wq_q    <= wq_d;
      dv_q    <= dv_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider against an arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_chk = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] eq, output logic [W-1:0] er);
`ifdef SIGNED_DIV_EN
    int sa, sb, iq, ir;
    sa = $signed(ta);
    sb = $signed(tb);
    if (sb == 0) begin
      iq = -1; ir = sa;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      iq = sa; ir = 0;
    end else begin
      iq = sa / sb; ir = sa % sb;
    end
    eq = iq[W-1:0];
    er = ir[W-1:0];
`else
    if (tb == 0) begin
      eq = '1; er = ta;
    end else begin
      eq = ta / tb; er = ta % tb;
    end
`endif
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Launch one operation (inputs set before the edge), scramble operands after
  // capture, and check latency, busy and results against the model.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input string tag);
    logic [W-1:0] eq, er;
    int cyc;
    model(ta, tb, eq, er);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk({tag, "_busy"}, busy, (tb != 0));
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, (tb == 0) ? 0 : W);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, (tb == 0));
    chk({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    start = 1'b0; a = '0; b = '0; rst = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    do_op(4'd13, 4'd3, "basic");
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    do_op(4'd15, 4'd1, "e15_1");
    do_op(4'd2,  4'd9, "e2_9");
    do_op(4'd0,  4'd5, "e0_5");
    do_op(4'd7,  4'd0, "dz7");
    do_op(4'd6,  4'd4, "after_dz");

    // Start while busy must be ignored; start in the done cycle is accepted.
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_cycles(1);
    a = 4'd9; b = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cnt = 0;
    while (!done && cnt < 3 * W) begin
      @(posedge clk); #1; cnt++;
    end
    chk("bp_lat", cnt, W - 2);
    begin
      logic [W-1:0] eq, er;
      model(4'd12, 4'd5, eq, er);
      chk("bp_q", quotient, eq);
      chk("bp_r", remainder, er);
    end
    do_op(4'd9, 4'd2, "b2b");
    count_done(W + 2, cnt);
    chk("no_extra_done", cnt, 0);

    // Reset in the middle of a run aborts without a done.
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_cycles(2);
    rst = 1'b1; #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    count_done(W + 2, cnt);
    chk("mrst_nodone", cnt, 0);
    @(negedge clk);
    do_op(4'd14, 4'd3, "post_rst");

`ifdef SIGNED_DIV_EN
    do_op(4'b1001, 4'd2, "s_m7_2");
    chk("s_m7_2_qx", quotient, 4'b1101);
    chk("s_m7_2_rx", remainder, 4'b1111);
    do_op(4'b1000, 4'b1111, "s_m8_m1");
    chk("s_m8_m1_qx", quotient, 4'b1000);
    chk("s_m8_m1_rx", remainder, 4'b0000);
`else
    chk("basic_qx", 32'(4'd13 / 4'd3), 4);
`endif

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      do_op(W'($urandom), W'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
